// File: rtl/wam_display_driver.sv
// Four-digit multiplexed 7-segment driver for the whack-a-mole game: score, lives, state glyph, mole on dp.
// Optional blinking of the END_SCREEN display is enabled by defining WAM_DISPLAY_BLINK_EN.
module wam_display_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mole,
    input  logic [3:0] score,
    input  logic [3:0] lives,
    input  logic [2:0] state,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PLAY = 3'd1;
    localparam logic [2:0] ST_END  = 3'd2;

    typedef struct packed {
        logic       mole;
        logic [3:0] score;
        logic [3:0] lives;
        logic [2:0] state;
    } snap_t;

    function automatic logic [6:0] dec_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] state_glyph(input logic [2:0] st);
        logic [6:0] g;
        case (st)
            ST_IDLE: g = 7'h4F;
            ST_PLAY: g = 7'h42;
            ST_END:  g = 7'h06;
            default: g = 7'h3F;
        endcase
        return g;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    snap_t         snap_q, snap_d;
    logic          load_q;
    logic [3:0]    an_q, an_d, an_raw_s;
    logic [6:0]    seg_q, seg_d, seg_raw_s;
    logic          dp_q, dp_d, dp_raw_s;
    logic          tick_s, wrap_s, blank_s;
    logic [3:0]    ones_s, lives_s;

    // Refresh counter, digit index and frame-boundary snapshot selection
    always_comb begin
        tick_s = (cnt_q == CNT_MAX);
        wrap_s = tick_s && (dig_q == 2'd3);
        if (tick_s) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            dig_d = dig_q;
        end
        if (wrap_s || load_q) begin
            snap_d = {mole, score, lives, state};
        end else begin
            snap_d = snap_q;
        end
    end

    // Decode the next digit from the snapshot that will be live for that frame
    always_comb begin
        ones_s    = (snap_d.score >= 4'd10) ? (snap_d.score - 4'd10) : snap_d.score;
        lives_s   = (snap_d.lives > 4'd9) ? 4'd9 : snap_d.lives;
        an_raw_s  = 4'b1111;
        seg_raw_s = 7'h7F;
        dp_raw_s  = 1'b1;
        case (dig_d)
            2'd0: begin
                an_raw_s  = 4'b1110;
                seg_raw_s = dec_glyph(ones_s);
                dp_raw_s  = ~snap_d.mole;
            end
            2'd1: begin
                an_raw_s  = 4'b1101;
                seg_raw_s = (snap_d.score >= 4'd10) ? dec_glyph(4'd1) : 7'h7F;
            end
            2'd2: begin
                an_raw_s  = 4'b1011;
                seg_raw_s = dec_glyph(lives_s);
            end
            2'd3: begin
                an_raw_s  = 4'b0111;
                seg_raw_s = state_glyph(snap_d.state);
            end
            default: begin
                an_raw_s  = 4'b1111;
                seg_raw_s = 7'h7F;
            end
        endcase
        if (tick_s) begin
            an_d  = blank_s ? 4'b1111 : an_raw_s;
            seg_d = blank_s ? 7'h7F : seg_raw_s;
            dp_d  = blank_s ? 1'b1 : dp_raw_s;
        end else begin
            an_d  = an_q;
            seg_d = seg_q;
            dp_d  = dp_q;
        end
    end

    // Scan state and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            dig_q  <= 2'd3;
            snap_q <= '0;
            load_q <= 1'b1;
            an_q   <= 4'b1111;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            snap_q <= snap_d;
            load_q <= 1'b0;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

`ifdef WAM_DISPLAY_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          vis_q, vis_d;
    logic          started_q, started_d;
    logic          frame_end_s;

    // The wrap that starts the first frame after reset completes no frame
    always_comb begin
        frame_end_s = wrap_s && started_q;
        started_d   = started_q | wrap_s;
        if (frame_end_s) begin
            if (frame_q == FRM_MAX) begin
                frame_d = '0;
                vis_d   = ~vis_q;
            end else begin
                frame_d = frame_q + FW'(1);
                vis_d   = vis_q;
            end
        end else begin
            frame_d = frame_q;
            vis_d   = vis_q;
        end
        blank_s = ~vis_d && (snap_d.state == ST_END);
    end

    // Frame counter and blink phase
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q   <= '0;
            vis_q     <= 1'b1;
            started_q <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            vis_q     <= vis_d;
            started_q <= started_d;
        end
    end
`else
    logic unused_blink_s;
    assign unused_blink_s = (BLINK_FRAMES > 0);
    assign blank_s        = 1'b0;
`endif

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_wam_display_driver.sv
// Directed bench for wam_display_driver: expected digit slots are queued, then checked cycle by cycle.
module tb_wam_display_driver;

    localparam int RD = 4;
`ifdef WAM_DISPLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       mole;
    logic [3:0] score;
    logic [3:0] lives;
    logic [2:0] state;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    wam_display_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .mole  (mole),
        .score (score),
        .lives (lives),
        .state (state),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        sb_q.push_back(e);
    endtask

    task automatic push_digit(input int idx, input logic [6:0] s, input logic d);
        logic [3:0] a;
        a      = 4'b1111;
        a[idx] = 1'b0;
        push_exp(a, s, d);
    endtask

    task automatic push_blank();
        push_exp(4'b1111, 7'h7F, 1'b1);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic d0);
        push_digit(0, s0, d0);
        push_digit(1, s1, 1'b1);
        push_digit(2, s2, 1'b1);
        push_digit(3, s3, 1'b1);
    endtask

    // Pop one expected slot and hold it against the outputs for n consecutive cycles
    task automatic check_slot(input int n, input string tag);
        exp_t e;
        exp_t obs;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, got nothing, want an entry", tag);
        end else begin
            e = sb_q.pop_front();
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                obs.an  = an;
                obs.seg = seg;
                obs.dp  = dp;
                vectors++;
                assert (obs === e) else begin
                    miscompares++;
                    $error("FAIL %s cyc %0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                           tag, c, obs.an, obs.seg, obs.dp, e.an, e.seg, e.dp);
                end
            end
        end
    endtask

    task automatic check_frame(input string tag);
        for (int d = 0; d < 4; d++) begin
            check_slot(RD, $sformatf("%s_d%0d", tag, d));
        end
    endtask

    initial begin
        reset = 1'b1;
        mole  = 1'b0;
        score = 4'd13;
        lives = 4'd3;
        state = 3'd1;

        // Reset held 3 cycles, then REFRESH_DIV-1 blank cycles before digit 0
        push_blank();
        check_slot(3, "reset");
        reset = 1'b0;
        push_blank();
        check_slot(RD - 1, "prescan");
        push_frame(7'h30, 7'h79, 7'h30, 7'h42, 1'b1);
        check_frame("s13");

        score = 4'd7;
        lives = 4'd12;
        state = 3'd5;
        mole  = 1'b1;
        push_frame(7'h78, 7'h7F, 7'h10, 7'h3F, 1'b0);
        check_frame("s7");

        // Score changes 5->6 while digit 2 is lit; takes effect at next frame
        score = 4'd5;
        lives = 4'd4;
        state = 3'd0;
        mole  = 1'b0;
        push_digit(0, 7'h12, 1'b1);
        push_digit(1, 7'h7F, 1'b1);
        push_digit(2, 7'h19, 1'b1);
        push_digit(2, 7'h19, 1'b1);
        push_digit(3, 7'h4F, 1'b1);
        check_slot(RD, "s5_d0");
        check_slot(RD, "s5_d1");
        check_slot(1, "s5_d2a");
        score = 4'd6;
        check_slot(RD - 1, "s5_d2b");
        check_slot(RD, "s5_d3");
        push_frame(7'h02, 7'h7F, 7'h19, 7'h4F, 1'b1);
        check_frame("s6");

        // Reset during digit 2
        push_digit(0, 7'h02, 1'b1);
        push_digit(1, 7'h7F, 1'b1);
        push_digit(2, 7'h19, 1'b1);
        check_slot(RD, "pre_rst_d0");
        check_slot(RD, "pre_rst_d1");
        check_slot(1, "pre_rst_d2");
        reset = 1'b1;
        push_blank();
        check_slot(2, "rst_mid");
        reset = 1'b0;
        push_blank();
        check_slot(RD - 1, "rst_rel");
        push_frame(7'h02, 7'h7F, 7'h19, 7'h4F, 1'b1);
        check_frame("restart");

        // END_SCREEN: blinking two frames off every two frames only when enabled
        score = 4'd0;
        lives = 4'd0;
        state = 3'd2;
        reset = 1'b1;
        push_blank();
        check_slot(2, "end_rst");
        reset = 1'b0;
        push_blank();
        check_slot(RD - 1, "end_pre");
        for (int f = 1; f <= 6; f++) begin
            if (BLINK && (f == 3 || f == 4)) begin
                for (int d = 0; d < 4; d++) begin
                    push_blank();
                end
            end else begin
                push_frame(7'h40, 7'h7F, 7'h40, 7'h06, 1'b1);
            end
            check_frame($sformatf("end_f%0d", f));
        end

        vectors++;
        assert (sb_q.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drain: got %0d leftover entries, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wam_display_driver.md
WAM_DISPLAY_DRIVER -- requirements
Module: wam_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter BLINK_FRAMES, default 125: full 4-digit scan frames per blink half-period.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port mole, input, 1: mole visible flag from game core.
REQ-006 SHALL have port score, input, 4: player score, 0-15.
REQ-007 SHALL have port lives, input, 4: player lives.
REQ-008 SHALL have port state, input, 3: game state; 0=IDLE, 1=GAMEPLAY, 2=END_SCREEN, other=invalid.
REQ-009 SHALL have port an, output, 4: digit anodes, active-low, one-hot-low.
REQ-010 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp, output, 1: decimal point, active-low.

Function
REQ-012 SHALL count 0..REFRESH_DIV-1 with a refresh counter; at terminal count, wrap to 0 and advance 2-bit digit index 0->1->2->3->0.
REQ-013 SHALL capture mole, score, lives, state into a snapshot register only in the cycle when digit index wraps 3->0, and at reset release; displayed values never change mid-frame.
REQ-014 SHALL drive an, seg, dp from registers updated in the same cycle the digit index changes; an and seg never disagree for any cycle.
REQ-015 SHALL show on digit 0 (an=1110) the score ones digit (score mod 10) in decimal.
REQ-016 SHALL show on digit 1 (an=1101) the score tens digit; blank (seg=7F) when score < 10.
REQ-017 SHALL show on digit 2 (an=1011) lives as decimal, clamped: lives > 9 displays 9.
REQ-018 SHALL show on digit 3 (an=0111) a state glyph: IDLE "I" (e,f); GAMEPLAY "G" (a,c,d,e,f); END_SCREEN "E" (a,d,e,f,g); invalid "-" (g only).
REQ-019 SHALL drive dp=0 only on digit 0 while snapshot mole=1; dp=1 otherwise.
REQ-020 SHALL use standard decimal glyphs 0-9 (e.g., 0=7'h40, 1=7'h79, 8=7'h00 active-low).
REQ-021 SHALL count completed frames with a frame counter 0..BLINK_FRAMES-1, toggling a blink phase on wrap.
REQ-022 SHALL, on score or lives snapshot change, take effect at the next frame boundary with a latency of at most 4*REFRESH_DIV+1 cycles from the input change.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, set an=4'b1111, seg=7'h7F, dp=1, refresh counter=0, digit index=3, frame counter=0, blink phase=visible, snapshot=0.
REQ-024 SHALL, on first non-reset cycle, load the snapshot and begin digit 0 after REFRESH_DIV cycles; reset mid-frame aborts the frame immediately.

Configuration
REQ-025 SHALL, with macro WAM_DISPLAY_BLINK_EN defined, blank all digits (an=4'b1111) during the blink-off phase while snapshot state=END_SCREEN; counters keep running.
REQ-026 SHALL, without WAM_DISPLAY_BLINK_EN, omit frame counter and blink logic; END_SCREEN displays steadily.
REQ-027 SHALL leave display contents and timing otherwise identical in both configurations.

Verification
REQ-028 SHALL cover: REFRESH_DIV=4, reset held 3 cycles -> an=1111, seg=7F, dp=1 throughout; then an steps 1110,1101,1011,0111 every 4 cycles.
REQ-029 SHALL cover: score=13, lives=3, state=1, mole=0 -> digit0 seg=7'h30, digit1 seg=7'h79, digit2 seg=7'h30, digit3 "G" seg=7'h42, dp=1.
REQ-030 SHALL cover: score=7, lives=12, state=5, mole=1 -> digit1 blank 7F, digit2 shows 9 (7'h10), digit3 dash 7'h3F, dp=0 only on digit0.
REQ-031 SHALL cover: score changed 5->6 while digit 2 active -> digits still show 5 until frame wraps, then 6 within 4*REFRESH_DIV+1 cycles.
REQ-032 SHALL cover: WAM_DISPLAY_BLINK_EN defined, BLINK_FRAMES=2, state=2 -> an alternates all-off for 2 frames and scanning for 2 frames; undefined -> continuous scanning.
REQ-033 SHALL cover: reset asserted during digit 2 -> outputs blank next edge; after release scan restarts with digit 0.
